alu_iter: RTL
=============

Name: alu_iter

Overview:
- Execute-stage ALU that consumes the 3-bit ALU operation code from the ALU control decoder.
- Arithmetic and logic ops complete in one registered cycle. Shifts (sll/srl) run iteratively, one bit per cycle, under a start/busy/done handshake.
- Result and zero flag are registered and feed writeback and the branch-compare logic.

Parameters:
- WIDTH, 32, datapath width of a, b and result.
- SHW, 5, shift-amount width; must satisfy 2**SHW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; accepted on a rising edge when busy=0.
- ALUOperation  input  3  op code, sampled with start: 010 add, 110 sub, 000 and, 001 or, 111 slt, 101 sll, 011 srl, 100 reserved.
- a  input  WIDTH  operand A (rs); sampled with start.
- b  input  WIDTH  operand B (rt or immediate); the shifted operand for sll/srl; sampled with start.
- shamt  input  SHW  shift amount; sampled with start; ignored for non-shift ops.
- result  output  WIDTH  registered result; holds its value until the next done.
- zero  output  1  registered, equals (result == 0); updates together with result.
- busy  output  1  high while in state SHIFT.
- done  output  1  one-cycle pulse; result and zero are valid in that cycle.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, result 0, zero 1, busy 0, done 0, shift counter 0.
- States:
  - IDLE.
  - SHIFT: working register plus down-counter.
  - DONE: done=1 for exactly one cycle.
- Acceptance:
  - start is accepted in IDLE or DONE (back-to-back issue allowed).
  - start is ignored in SHIFT; the inputs are not captured.
- Non-shift op accepted: compute on the sampled operands, load result/zero, go to DONE. Latency 1 edge.
- Shift op accepted:
  - Working register loads b and the counter loads shamt.
  - If shamt == 0: result = b, go to DONE (latency 1).
  - Otherwise go to SHIFT.
- In SHIFT, each edge:
  - sll shifts the working register left by 1, filling with 0.
  - srl shifts it right by 1, logical, filling with 0.
  - The counter decrements.
  - When the counter goes 1 -> 0, result/zero load the shifted value and the state goes to DONE.
  - Total latency shamt+1 edges from the start edge to done high.
- DONE: without start, go to IDLE; with start, accept the new op as above.
- Arithmetic:
  - add/sub wrap modulo 2**WIDTH; no overflow flag, no trap.
  - slt: result = {0..., signed(a) < signed(b)}. It must be correct when a-b overflows (a=0x7FFFFFFF, b=0x80000000 gives 0).
  - and/or are bitwise.
- Reserved code 100 (feature off): result=0, zero=1, done pulses normally.
- Rules:
  - result/zero change only on the edge that enters DONE.
  - During SHIFT they hold the previous op's values.
  - rst asserted mid-SHIFT aborts the op: no done, outputs take their reset values.
  - rst and start in the same cycle: rst wins.

Optional Feature:
- Macro ALU_NOR_EN.
- Defined: code 100 performs bitwise NOR, result = ~(a | b), latency 1.
- Undefined: code 100 gives result 0, zero 1, latency 1.
- All other codes behave identically in both builds.

Test Plan:
- Reset: rst high 2 cycles -> result 0, zero 1, busy 0, done 0.
- add: a=0xFFFFFFFF, b=1, op 010 -> done 1 edge later, result 0, zero 1. sub: a=5, b=7, op 110 -> result 0xFFFFFFFE, zero 0.
- slt overflow: a=0x7FFFFFFF, b=0x80000000 -> result 0. a=0x80000000, b=1 -> result 1.
- sll: b=0x00000003, shamt=4, op 101 -> busy high 4 cycles, done on edge 5, result 0x30. srl: b=0x80000000, shamt=31 -> result 1 after 32 edges. shamt=0 -> result=b after 1 edge.
- Handshake:
  - start pulsed mid-SHIFT -> ignored; result unchanged until the original shift's done.
  - start in the DONE cycle with op and: a=0xF0F0, b=0xFF00 -> accepted; result 0xF000 one edge later.
- Reset mid-op and feature:
  - rst asserted on shift cycle 2 of shamt=10 -> no done pulse, outputs at reset values.
  - op 100 with a=0, b=0 -> 0xFFFFFFFF if ALU_NOR_EN is defined, else 0.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with single-cycle arithmetic/logic ops and
// iterative one-bit-per-cycle shifts (sll/srl) under a start/busy/done
// handshake. Result and zero flag are registered.
//
// Handshake: a request is presented by holding start high with ALUOperation,
// a, b and shamt stable across a rising edge; it is accepted on that edge
// only when busy is low (state IDLE or DONE). While busy is high, start is
// ignored and the inputs are not captured. done is high for one cycle per
// completed op, and result/zero are valid from that cycle until the next done.
//
// Optional build macro ALU_NOR_EN: when defined, op code 100 performs a
// bitwise NOR; when undefined, op code 100 yields result 0, zero 1.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_RSV = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic             is_shift;
  logic             slt_bit;

  // Signed compare done directly rather than from the sign of a-b, so it
  // stays correct when the subtraction overflows.
  assign slt_bit  = ($signed(a) < $signed(b));
  assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);

  // Single-cycle arithmetic/logic result for the currently presented op.
  always_comb begin
    alu_res = '0;
    case (ALUOperation)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
`ifdef ALU_NOR_EN
      OP_RSV: alu_res = ~(a | b);
`else
      OP_RSV: alu_res = '0;
`endif
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: acceptance in IDLE/DONE, one shift step per SHIFT cycle.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      SHIFT: begin
        if (left_q) work_d = {work_q[WIDTH-2:0], 1'b0};
        else        work_d = {1'b0, work_q[WIDTH-1:1]};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = work_d;
          zero_d   = (work_d == '0);
          state_d  = DONE;
        end
      end
      default: begin
        if (start) begin
          if (is_shift) begin
            work_d = b;
            cnt_d  = shamt;
            left_d = (ALUOperation == OP_SLL);
            if (shamt == '0) begin
              result_d = b;
              zero_d   = (b == '0);
              state_d  = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);

endmodule
